// File: rtl/alu_simd_acc_stage.sv
// Output/accumulation stage behind the 54-bit SIMD three-input adder: registers S, feeds it
// back as W for a frame of ACC_LEN samples, tracks sticky lane overflow, hands P off via valid/ready.
module alu_simd_acc_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  USE_SIMD_IN,
    input  logic [7:0]  ACC_LEN,
    input  logic        FLUSH,
    input  logic [53:0] S,
    input  logic        S_VALID,
    output logic        S_READY,
    input  logic [23:0] SIMD_COUT,
    output logic [1:0]  USE_SIMD,
    output logic [53:0] W_FB,
    output logic [53:0] P,
    output logic        P_VALID,
    input  logic        P_READY,
    output logic [11:0] OVF
);

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e      state_q, state_d;
    logic [53:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] ovf_q, ovf_d;

    logic [1:0]  eff_mode;
    logic [7:0]  len_in;
    logic [7:0]  cnt_inc;
    logic [11:0] seg_carry;
    logic [11:0] new_ovf;
    logic        accept;

    // Segment widths 4,4,6,4 repeat three times; a lane top is the segment holding a lane MSB.
    function automatic logic [11:0] lane_tops(input logic [1:0] mode);
        logic [11:0] tops;
        case (mode)
            2'b00:   tops = 12'h800;
            2'b01:   tops = 12'h888;
            2'b10:   tops = 12'hAAA;
            default: tops = 12'hFFF;
        endcase
        return tops;
    endfunction

    always_comb begin
        seg_carry = '0;
        for (int i = 0; i < 12; i++) begin
            seg_carry[i] = |SIMD_COUT[2*i +: 2];
        end
    end

    // The adder sees the requested mode while idle so the first sample is computed in it.
    assign eff_mode = (state_q == StIdle) ? USE_SIMD_IN : mode_q;
    assign new_ovf  = lane_tops(eff_mode) & seg_carry;
    assign len_in   = (ACC_LEN == 8'd0) ? 8'd1 : ACC_LEN;
    assign cnt_inc  = cnt_q + 8'd1;
    assign S_READY  = (state_q == StIdle) || (state_q == StAcc);
    assign accept   = S_VALID && S_READY;

    assign USE_SIMD = eff_mode;
    assign W_FB     = (state_q == StAcc) ? acc_q : 54'd0;
    assign P_VALID  = (state_q == StDone);
    assign P        = P_VALID ? acc_q : 54'd0;
    assign OVF      = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d = USE_SIMD_IN;
                    len_d  = len_in;
                    acc_d  = S;
                    cnt_d  = 8'd1;
                    ovf_d  = new_ovf;
                    if ((len_in == 8'd1) || FLUSH) begin
                        state_d = StDone;
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                if (accept) begin
                    acc_d = S;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | new_ovf;
                    if ((cnt_inc == len_q) || FLUSH) begin
                        state_d = StDone;
                    end
                end else if (FLUSH) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (P_READY) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= 8'd1;
            mode_q  <= 2'b00;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_simd_acc_stage.sv
// Directed bench for alu_simd_acc_stage: single-sample frame table plus multi-cycle sequences.
module tb_alu_simd_acc_stage;

    logic        clk;
    logic        rst_n;
    logic [1:0]  USE_SIMD_IN;
    logic [7:0]  ACC_LEN;
    logic        FLUSH;
    logic [53:0] S;
    logic        S_VALID;
    logic        S_READY;
    logic [23:0] SIMD_COUT;
    logic [1:0]  USE_SIMD;
    logic [53:0] W_FB;
    logic [53:0] P;
    logic        P_VALID;
    logic        P_READY;
    logic [11:0] OVF;

    int checks = 0;
    int errors = 0;

    alu_simd_acc_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .USE_SIMD_IN (USE_SIMD_IN),
        .ACC_LEN     (ACC_LEN),
        .FLUSH       (FLUSH),
        .S           (S),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .SIMD_COUT   (SIMD_COUT),
        .USE_SIMD    (USE_SIMD),
        .W_FB        (W_FB),
        .P           (P),
        .P_VALID     (P_VALID),
        .P_READY     (P_READY),
        .OVF         (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  len;
        logic [53:0] s;
        logic [23:0] cout;
        logic [53:0] exp_p;
        logic [11:0] exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; presents one sample, checks W_FB, returns at the next negedge.
    task automatic send(input logic [53:0] s, input logic [23:0] cout, input logic [53:0] exp_w,
                        input string name);
        S         = s;
        SIMD_COUT = cout;
        S_VALID   = 1'b1;
        #1;
        chk({name, " W_FB"}, 64'(W_FB), 64'(exp_w));
        chk({name, " S_READY"}, 64'(S_READY), 64'd1);
        @(negedge clk);
        S_VALID   = 1'b0;
        SIMD_COUT = '0;
    endtask

    task automatic release_p(input string name);
        P_READY = 1'b1;
        @(negedge clk);
        P_READY = 1'b0;
        #1;
        chk({name, " idle P_VALID"}, 64'(P_VALID), 64'd0);
        chk({name, " idle P"}, 64'(P), 64'd0);
        chk({name, " idle S_READY"}, 64'(S_READY), 64'd1);
    endtask

    initial begin
        vecs[0] = '{2'b00, 8'd1, 54'h123, 24'h000003, 54'h123, 12'h000};
        vecs[1] = '{2'b00, 8'd0, 54'h3F_FFFF_FFFF_FFFF, 24'h800000, 54'h3F_FFFF_FFFF_FFFF, 12'h800};
        vecs[2] = '{2'b01, 8'd1, 54'hABCDE, 24'h004C00, 54'hABCDE, 12'h080};
        vecs[3] = '{2'b10, 8'd1, 54'h777, 24'h000014, 54'h777, 12'h002};
        vecs[4] = '{2'b11, 8'd0, 54'h5A, 24'h0C0010, 54'h5A, 12'h204};
        vecs[5] = '{2'b01, 8'd1, 54'h1, 24'hFFFFFF, 54'h1, 12'h888};
        vecs[6] = '{2'b10, 8'd0, 54'h2, 24'hFFFFFF, 54'h2, 12'hAAA};

        rst_n = 1'b0;
        USE_SIMD_IN = 2'b10;
        ACC_LEN = 8'd0;
        FLUSH = 1'b0;
        S = '0;
        S_VALID = 1'b0;
        SIMD_COUT = '0;
        P_READY = 1'b0;
        #12;
        chk("reset P_VALID", 64'(P_VALID), 64'd0);
        chk("reset P", 64'(P), 64'd0);
        chk("reset OVF", 64'(OVF), 64'd0);
        chk("reset W_FB", 64'(W_FB), 64'd0);
        chk("reset S_READY", 64'(S_READY), 64'd1);
        chk("reset USE_SIMD", 64'(USE_SIMD), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-sample frames (length 0 or 1).
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            USE_SIMD_IN = vecs[i].mode;
            ACC_LEN     = vecs[i].len;
            #1;
            chk($sformatf("vec%0d USE_SIMD idle", i), 64'(USE_SIMD), 64'(vecs[i].mode));
            @(negedge clk);
            send(vecs[i].s, vecs[i].cout, 54'd0, $sformatf("vec%0d", i));
            USE_SIMD_IN = ~vecs[i].mode;
            #1;
            chk($sformatf("vec%0d P_VALID", i), 64'(P_VALID), 64'd1);
            chk($sformatf("vec%0d P", i), 64'(P), 64'(vecs[i].exp_p));
            chk($sformatf("vec%0d OVF", i), 64'(OVF), 64'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d USE_SIMD done", i), 64'(USE_SIMD), 64'(vecs[i].mode));
            chk($sformatf("vec%0d S_READY done", i), 64'(S_READY), 64'd0);
            chk($sformatf("vec%0d W_FB done", i), 64'(W_FB), 64'd0);
            release_p($sformatf("vec%0d", i));
        end

        // Basic three-sample frame.
        @(negedge clk);
        USE_SIMD_IN = 2'b00;
        ACC_LEN = 8'd3;
        send(54'd10, 24'd0, 54'd0, "basic s0");
        send(54'd25, 24'd0, 54'd10, "basic s1");
        send(54'd40, 24'd0, 54'd25, "basic s2");
        #1;
        chk("basic P_VALID", 64'(P_VALID), 64'd1);
        chk("basic P", 64'(P), 64'd40);
        chk("basic OVF", 64'(OVF), 64'd0);
        release_p("basic");

        // Mode latch across a length-4 frame.
        @(negedge clk);
        USE_SIMD_IN = 2'b11;
        ACC_LEN = 8'd4;
        send(54'd1, 24'd0, 54'd0, "latch s0");
        USE_SIMD_IN = 2'b01;
        ACC_LEN = 8'd1;
        #1;
        chk("latch USE_SIMD acc", 64'(USE_SIMD), 64'd3);
        @(negedge clk);
        send(54'd2, 24'd0, 54'd1, "latch s1");
        send(54'd3, 24'd0, 54'd2, "latch s2");
        chk("latch P_VALID early", 64'(P_VALID), 64'd0);
        send(54'd4, 24'd0, 54'd3, "latch s3");
        #1;
        chk("latch P", 64'(P), 64'd4);
        chk("latch USE_SIMD done", 64'(USE_SIMD), 64'd3);
        release_p("latch");
        chk("latch USE_SIMD idle", 64'(USE_SIMD), 64'd1);

        // Overflow masking: segment 2 is not a lane top in sum_9x9.
        @(negedge clk);
        USE_SIMD_IN = 2'b01;
        ACC_LEN = 8'd2;
        send(54'h100, 24'h000040, 54'd0, "ovf s0");
        send(54'h200, 24'h000010, 54'h100, "ovf s1");
        #1;
        chk("ovf P", 64'(P), 64'h200);
        chk("ovf OVF", 64'(OVF), 64'h008);
        release_p("ovf");

        // FLUSH while idle is ignored.
        @(negedge clk);
        FLUSH = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        #1;
        chk("idle flush P_VALID", 64'(P_VALID), 64'd0);
        chk("idle flush S_READY", 64'(S_READY), 64'd1);

        // Flush without a sample, then stall with P_READY low.
        @(negedge clk);
        USE_SIMD_IN = 2'b00;
        ACC_LEN = 8'd10;
        send(54'h111, 24'd0, 54'd0, "flush s0");
        send(54'h222, 24'd0, 54'h111, "flush s1");
        send(54'h333, 24'd0, 54'h222, "flush s2");
        chk("flush P_VALID before", 64'(P_VALID), 64'd0);
        FLUSH = 1'b1;
        @(negedge clk);
        FLUSH = 1'b0;
        S_VALID = 1'b1;
        S = 54'h999;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d P_VALID", c), 64'(P_VALID), 64'd1);
            chk($sformatf("stall%0d P", c), 64'(P), 64'h333);
            chk($sformatf("stall%0d S_READY", c), 64'(S_READY), 64'd0);
            @(negedge clk);
        end
        P_READY = 1'b1;
        #1;
        chk("stall release S_READY", 64'(S_READY), 64'd0);
        @(negedge clk);
        S_VALID = 1'b0;
        P_READY = 1'b0;
        #1;
        chk("stall idle P_VALID", 64'(P_VALID), 64'd0);

        // FLUSH together with a sample includes that sample.
        @(negedge clk);
        ACC_LEN = 8'd10;
        send(54'h5, 24'd0, 54'd0, "flushacc s0");
        FLUSH = 1'b1;
        send(54'h6, 24'd0, 54'h5, "flushacc s1");
        FLUSH = 1'b0;
        #1;
        chk("flushacc P_VALID", 64'(P_VALID), 64'd1);
        chk("flushacc P", 64'(P), 64'h6);
        release_p("flushacc");

        // Asynchronous reset in the middle of a frame.
        @(negedge clk);
        USE_SIMD_IN = 2'b11;
        ACC_LEN = 8'd5;
        send(54'h44, 24'h000001, 54'd0, "rst s0");
        send(54'h55, 24'd0, 54'h44, "rst s1");
        #1;
        chk("rst OVF before", 64'(OVF), 64'h001);
        chk("rst W_FB before", 64'(W_FB), 64'h55);
        USE_SIMD_IN = 2'b10;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst W_FB", 64'(W_FB), 64'd0);
        chk("rst OVF", 64'(OVF), 64'd0);
        chk("rst P_VALID", 64'(P_VALID), 64'd0);
        chk("rst S_READY", 64'(S_READY), 64'd1);
        chk("rst USE_SIMD", 64'(USE_SIMD), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        USE_SIMD_IN = 2'b00;
        ACC_LEN = 8'd1;
        send(54'h7, 24'd0, 54'd0, "post s0");
        #1;
        chk("post P", 64'(P), 64'h7);
        chk("post OVF", 64'(OVF), 64'd0);
        release_p("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_simd_acc_stage.md
# alu_simd_acc_stage

Output/accumulation stage placed directly downstream of the 54-bit SIMD three-input adder (modes 27x27, sum-9x9, sum-4x4, sum-2x2). It registers the adder sum `S`, feeds it back to the adder's `W` operand for a programmable number of accumulation steps, and tracks sticky per-lane overflow from the adder's SIMD carry-outs. It presents the finished result through a valid/ready handshake. It also owns the SIMD mode seen by the adder, holding it constant for a whole accumulation frame.

## Interface
- No parameters. The widths are fixed by the adder: a 54-bit datapath, 12 segments, and 24 carry bits.
- `clk` — input, 1 bit. Single clock; all state is updated on the rising edge.
- `rst_n` — input, 1 bit. Reset is asynchronous and active-low.
- `USE_SIMD_IN` — input, 2 bits. Requested mode: 00 = 27x27, 01 = sum_9x9, 10 = sum_4x4, 11 = sum_2x2.
- `ACC_LEN` — input, 8 bits. Number of samples per frame; 0 is treated as 1.
- `FLUSH` — input, 1 bit. Ends the current frame early.
- `S` — input, 54 bits. Adder sum.
- `S_VALID` — input, 1 bit. `S` is valid.
- `S_READY` — output, 1 bit. The stage accepts `S` this cycle.
- `SIMD_COUT` — input, 24 bits. Adder `result_SIMD_carry_out`; segment i uses bits [2i+1:2i].
- `USE_SIMD` — output, 2 bits. Latched mode, driven to the adder.
- `W_FB` — output, 54 bits. Feedback operand driven to the adder `W` port.
- `P` — output, 54 bits. Result of the frame.
- `P_VALID` — output, 1 bit. `P` is valid.
- `P_READY` — input, 1 bit. The consumer accepts `P`.
- `OVF` — output, 12 bits. Sticky per-segment lane overflow for the frame, valid together with `P`.

## Operation
- **Segment map.** Segment widths are 4,4,6,4,4,4,6,4,4,4,6,4, occupying bits [3:0] through [53:50].
- **Lane-top segments per mode:**
  - 00: segment 11.
  - 01: segments 3, 7, 11 (lanes [17:0], [35:18], [53:36]).
  - 10: odd segments.
  - 11: all segments.
- **States:** IDLE, ACC, DONE.
- **Handshake:** a sample is accepted when `S_VALID` and `S_READY` are both high. `S_READY` = (state is IDLE or ACC).
- **IDLE:**
  - `W_FB` = 0 and `USE_SIMD` = `USE_SIMD_IN` (combinational pass-through).
  - On accept:
    - latch `USE_SIMD_IN` into `mode_q` and `max(ACC_LEN,1)` into `len_q`;
    - set `acc` = `S`, `cnt` = 1, and `OVF` = that sample's lane-top overflow bits.
  - Next state: if `len_q` == 1 or `FLUSH` is high, go to DONE; otherwise go to ACC.
- **ACC:**
  - `W_FB` = `acc` and `USE_SIMD` = `mode_q`; `USE_SIMD_IN` and `ACC_LEN` are ignored.
  - On accept: set `acc` = `S`, `cnt` = `cnt`+1, and `OVF` |= new lane-top bits.
  - Next state: if (`cnt`+1 == `len_q`) or `FLUSH` is high, go to DONE.
  - `FLUSH` high without an accept also goes to DONE; `acc` is unchanged.
- **Overflow rule:** bit i of the new overflow bits = (segment i is a lane top in `mode_q`, or in the incoming mode when in IDLE) AND (`SIMD_COUT`[2i+1:2i] != 0). Bits for non-top segments are always 0.
- **DONE:**
  - `P_VALID` = 1, `P` = `acc`, `OVF` is held, `W_FB` = 0, and `USE_SIMD` = `mode_q`.
  - When `P_READY` is high, go to IDLE and clear `acc` and `cnt`. `OVF` is cleared on the next frame's first accept.
- `FLUSH` in IDLE is ignored.
- `P` is 0 whenever `P_VALID` is 0.
- `cnt` is 8 bits; it never wraps because DONE is reached at `len_q` ≤ 255.

## Timing
- **Reset values:** state IDLE, `acc` 0, `cnt` 0, `mode_q` 00, `len_q` 1, `P` 0, `P_VALID` 0, `OVF` 0, `W_FB` 0, `S_READY` 1, `USE_SIMD` = `USE_SIMD_IN`.
- **Reset mid-frame:** takes effect immediately and asynchronously; the partial frame is discarded.
- **Combinational paths:** `W_FB` and `USE_SIMD` are driven combinationally from registers only (plus the IDLE pass-through of `USE_SIMD_IN`). The adder loop `W_FB` → `S` is closed through the `acc` register, so there is no combinational loop inside this stage.
- **Latency:** `P_VALID` rises on the clock edge after the last accepted sample (or after `FLUSH`).
- **Throughput:** one DONE cycle is the minimum per frame, plus one bubble. `S_READY` = 0 throughout DONE, including the `P_READY` cycle.
- **Simultaneous events:** `FLUSH` together with an accept in ACC: the sample is included, then the stage goes to DONE.
- **Stall:** `P_READY` held low keeps DONE, `P`, and `OVF` stable indefinitely.

## Test plan
- **Basic frame:** after reset, mode 00, `ACC_LEN`=3; accept `S`=10, 25, 40 with carries 0. Required: `W_FB` = 0, 10, 25 at the accepting cycles; then `P_VALID`=1, `P`=40, `OVF`=0. `P_READY` → IDLE, `S_READY`=1.
- **Length 0 and mode latch:** `ACC_LEN`=0, mode 11, `S`=0x5A → DONE after 1 sample, `P`=0x5A, `USE_SIMD`=11. Also, changing `USE_SIMD_IN` to 01 during ACC of a len-4 frame keeps `USE_SIMD`=11 until IDLE.
- **Overflow masking:** mode 01, len 2; the first sample has `SIMD_COUT`[7:6]=01 (segment 3), the second has `SIMD_COUT`[5:4]=01 (segment 2, not a lane top). Required: `OVF`=0x008.
- **Flush and stall:** len 10, accept 3 samples, pulse `FLUSH` without `S_VALID` → `P` = 3rd sample. Hold `P_READY`=0 for 5 cycles → `P` stable and `S_READY`=0 while `S_VALID` is held high.
- **Reset mid-frame:** in ACC with `cnt`=2, assert `rst_n`=0 between edges → all outputs at their reset values immediately. The next frame starts fresh with `OVF`=0.
